// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: captures a request vector and emits one index per handshake.
// Optional out_cnt popcount port is enabled by defining ENC_CNT_EN.
module enc8to3_seq #(
    parameter bit PRIO_HIGH = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic [7:0] in,
    input  logic       in_valid,
    output logic       in_ready,
    output logic [2:0] out,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       out_last,
    output logic       busy
`ifdef ENC_CNT_EN
    ,
    output logic [3:0] out_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, EMIT = 1'b1} state_t;

    state_t     state, state_nxt;
    logic [7:0] pending, pending_nxt;
    logic       onehot;

    // Later matches overwrite earlier ones, so scan order picks the winner.
    function automatic logic [2:0] pick(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        if (PRIO_HIGH) begin
            for (int i = 0; i < 8; i++)
                if (v[i]) idx = 3'(i);
        end else begin
            for (int i = 7; i >= 0; i--)
                if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    function automatic logic [3:0] popcnt(input logic [7:0] v);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++)
            c = c + 4'(v[i]);
        return c;
    endfunction

    // pending is zero whenever IDLE, so out decodes to 0 there.
    assign out       = pick(pending);
    assign onehot    = (pending != 8'h00) && ((pending & (pending - 8'd1)) == 8'h00);
    assign out_valid = (state == EMIT);
    assign busy      = (state == EMIT);
    assign out_last  = (state == EMIT) && onehot;
    assign in_ready  = en && (state == IDLE);

    always_comb begin
        state_nxt   = state;
        pending_nxt = pending;
        case (state)
            IDLE: begin
                if (in_valid && in_ready && (in != 8'h00)) begin
                    pending_nxt = in;
                    state_nxt   = EMIT;
                end
            end
            EMIT: begin
                if (out_ready) begin
                    pending_nxt = pending & ~(8'd1 << out);
                    if (onehot) state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            pending <= 8'h00;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

`ifdef ENC_CNT_EN
    // Loaded on every acceptance, including dropped all-zero vectors.
    always_ff @(posedge clk) begin
        if (rst)
            out_cnt <= 4'd0;
        else if (in_valid && in_ready)
            out_cnt <= popcnt(in);
    end
`endif

endmodule

// File: tb/tb_enc8to3_seq.sv
// Directed table-driven bench for enc8to3_seq; both priority orders run on shared stimulus.
module tb_enc8to3_seq;

    logic       clk, rst, en, in_valid, out_ready;
    logic [7:0] in;
    logic       in_ready_h, out_valid_h, out_last_h, busy_h;
    logic       in_ready_l, out_valid_l, out_last_l, busy_l;
    logic [2:0] out_h, out_l;
    logic [3:0] cnt_h, cnt_l;

    int checks = 0;
    int errors = 0;

    enc8to3_seq #(.PRIO_HIGH(1'b1)) dut_hi (
        .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid), .in_ready(in_ready_h),
        .out(out_h), .out_valid(out_valid_h), .out_ready(out_ready), .out_last(out_last_h),
        .busy(busy_h)
`ifdef ENC_CNT_EN
        , .out_cnt(cnt_h)
`endif
    );

    enc8to3_seq #(.PRIO_HIGH(1'b0)) dut_lo (
        .clk(clk), .rst(rst), .en(en), .in(in), .in_valid(in_valid), .in_ready(in_ready_l),
        .out(out_l), .out_valid(out_valid_l), .out_ready(out_ready), .out_last(out_last_l),
        .busy(busy_l)
`ifdef ENC_CNT_EN
        , .out_cnt(cnt_l)
`endif
    );

`ifndef ENC_CNT_EN
    assign cnt_h = 4'd0;
    assign cnt_l = 4'd0;
`endif

    always #5 clk = ~clk;

    typedef struct {
        logic       rst, en, iv;
        logic [7:0] in;
        logic       ordy;
        logic [2:0] ohi, olo;
        logic       ov, last, busy, irdy;
        logic [3:0] cnt;
    } vec_t;

    vec_t tbl[29];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic [2:0] ohi, input logic [2:0] olo,
                           input logic ov, input logic last, input logic bsy,
                           input logic irdy, input logic [3:0] cnt);
        chk({tag, " out_hi"},   int'(out_h), int'(ohi));
        chk({tag, " out_lo"},   int'(out_l), int'(olo));
        chk({tag, " valid_hi"}, int'(out_valid_h), int'(ov));
        chk({tag, " valid_lo"}, int'(out_valid_l), int'(ov));
        chk({tag, " last_hi"},  int'(out_last_h), int'(last));
        chk({tag, " last_lo"},  int'(out_last_l), int'(last));
        chk({tag, " busy"},     int'(busy_h), int'(bsy));
        chk({tag, " busy_lo"},  int'(busy_l), int'(bsy));
        chk({tag, " in_ready"}, int'(in_ready_h), int'(irdy));
        chk({tag, " in_ready_lo"}, int'(in_ready_l), int'(irdy));
`ifdef ENC_CNT_EN
        chk({tag, " cnt_hi"}, int'(cnt_h), int'(cnt));
        chk({tag, " cnt_lo"}, int'(cnt_l), int'(cnt));
`endif
    endtask

    initial begin
        //          rst en iv in     ordy ohi olo ov last busy irdy cnt
        tbl[0]  = '{0, 1, 0, 8'h00, 1,   0,  0,  0, 0,   0,   1,   0};
        tbl[1]  = '{0, 1, 1, 8'hA4, 1,   0,  0,  0, 0,   0,   1,   0};
        tbl[2]  = '{0, 1, 0, 8'h00, 1,   7,  2,  1, 0,   1,   0,   3};
        tbl[3]  = '{0, 1, 1, 8'hFF, 1,   5,  5,  1, 0,   1,   0,   3};
        tbl[4]  = '{0, 1, 0, 8'h00, 1,   2,  7,  1, 1,   1,   0,   3};
        tbl[5]  = '{0, 1, 0, 8'h00, 1,   0,  0,  0, 0,   0,   1,   3};
        tbl[6]  = '{0, 1, 1, 8'h81, 0,   0,  0,  0, 0,   0,   1,   3};
        tbl[7]  = '{0, 1, 0, 8'h00, 0,   7,  0,  1, 0,   1,   0,   2};
        tbl[8]  = '{0, 1, 0, 8'h00, 0,   7,  0,  1, 0,   1,   0,   2};
        tbl[9]  = '{0, 1, 0, 8'h00, 0,   7,  0,  1, 0,   1,   0,   2};
        tbl[10] = '{0, 1, 0, 8'h00, 1,   7,  0,  1, 0,   1,   0,   2};
        tbl[11] = '{0, 1, 0, 8'h00, 1,   0,  7,  1, 1,   1,   0,   2};
        tbl[12] = '{0, 1, 0, 8'h00, 1,   0,  0,  0, 0,   0,   1,   2};
        tbl[13] = '{0, 0, 1, 8'h10, 1,   0,  0,  0, 0,   0,   0,   2};
        tbl[14] = '{0, 0, 1, 8'h10, 1,   0,  0,  0, 0,   0,   0,   2};
        tbl[15] = '{0, 1, 1, 8'h10, 1,   0,  0,  0, 0,   0,   1,   2};
        tbl[16] = '{0, 1, 0, 8'h00, 1,   4,  4,  1, 1,   1,   0,   1};
        tbl[17] = '{0, 1, 0, 8'h00, 1,   0,  0,  0, 0,   0,   1,   1};
        tbl[18] = '{0, 1, 1, 8'h00, 1,   0,  0,  0, 0,   0,   1,   1};
        tbl[19] = '{0, 1, 0, 8'h00, 1,   0,  0,  0, 0,   0,   1,   0};
        tbl[20] = '{0, 1, 1, 8'h41, 1,   0,  0,  0, 0,   0,   1,   0};
        tbl[21] = '{0, 0, 0, 8'h00, 1,   6,  0,  1, 0,   1,   0,   2};
        tbl[22] = '{0, 0, 0, 8'h00, 1,   0,  6,  1, 1,   1,   0,   2};
        tbl[23] = '{0, 0, 0, 8'h00, 1,   0,  0,  0, 0,   0,   0,   2};
        tbl[24] = '{0, 1, 1, 8'hFF, 1,   0,  0,  0, 0,   0,   1,   2};
        tbl[25] = '{0, 1, 0, 8'h00, 1,   7,  0,  1, 0,   1,   0,   8};
        tbl[26] = '{1, 1, 0, 8'h00, 1,   6,  1,  1, 0,   1,   0,   8};
        tbl[27] = '{1, 1, 0, 8'h00, 1,   0,  0,  0, 0,   0,   1,   0};
        tbl[28] = '{0, 1, 0, 8'h00, 1,   0,  0,  0, 0,   0,   1,   0};

        clk = 1'b0; rst = 1'b1; en = 1'b0; in_valid = 1'b0; in = 8'h00; out_ready = 1'b0;
        repeat (2) @(posedge clk);

        // Each row: drive before the edge, check pre-edge outputs.
        for (int r = 0; r < 29; r++) begin
            @(negedge clk);
            rst = tbl[r].rst; en = tbl[r].en; in_valid = tbl[r].iv;
            in = tbl[r].in; out_ready = tbl[r].ordy;
            #1;
            chk_all($sformatf("row%0d", r), tbl[r].ohi, tbl[r].olo, tbl[r].ov,
                    tbl[r].last, tbl[r].busy, tbl[r].irdy, tbl[r].cnt);
        end

        // Drop a zero vector, then a full vector emitted at full rate.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; in_valid = 1'b1; in = 8'h00; out_ready = 1'b1;
        #1 chk_all("zero_accept", 0, 0, 0, 0, 0, 1, 0);
        @(negedge clk);
        in = 8'hFF;
        #1 chk_all("zero_dropped", 0, 0, 0, 0, 0, 1, 0);
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            in_valid = 1'b0; in = 8'h00;
            #1 chk_all($sformatf("ff_code%0d", k), 3'(7 - k), 3'(k), 1, (k == 7), 1, 0, 8);
        end
        @(negedge clk);
        #1 chk_all("ff_done", 0, 0, 0, 0, 0, 1, 8);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
